digit_scan_ctrl: RTL and testbench

Upstream sequencer for the 2-to-4 one-hot address decoder: generates the binary `address` it consumes, stepping round-robin through the enabled outputs.
- Each selected output is held for a programmable dwell time, preceded by a blanking interval (anti-ghosting).
- A one-cycle `frame_done` pulse marks each completed scan pass.
- Intended to drive multiplexed display or row-scan logic.

---
 rtl/scan_pkg.sv | 54 +++++
 rtl/dwell_timer.sv | 48 ++++
 rtl/digit_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_digit_scan_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and helpers for the digit scan controller.
// No ports: provides the FSM state encoding, the next-index result
// struct, and the mask search functions used by digit_scan_ctrl.
package scan_pkg;

  // Helpers work on a fixed maximum mask width. Callers zero-extend
  // their mask, so unused upper bits never match.
  localparam int unsigned MAX_ADDR_W = 5;
  localparam int unsigned MAX_N      = 2 ** MAX_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic                  found;
    logic [MAX_ADDR_W-1:0] idx;
  } next_idx_t;

  // Priority search starting at cur+1 and wrapping back to cur itself.
  // Zero upper mask bits make the MAX_N wrap equal to a mod-N wrap.
  function automatic next_idx_t next_enabled(input logic [MAX_N-1:0]      mask,
                                             input logic [MAX_ADDR_W-1:0] cur);
    next_idx_t             res;
    logic [MAX_ADDR_W-1:0] pos;
    res = '0;
    for (int unsigned k = 1; k <= MAX_N; k++) begin
      pos = cur + MAX_ADDR_W'(k);
      if (!res.found && mask[pos]) begin
        res.found = 1'b1;
        res.idx   = pos;
      end
    end
    return res;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [MAX_ADDR_W-1:0] lowest_set(input logic [MAX_N-1:0] mask);
    logic [MAX_ADDR_W-1:0] idx;
    logic                  found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (!found && mask[k]) begin
        found = 1'b1;
        idx   = MAX_ADDR_W'(k);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Phase timer: counts cycles from a synchronous clear and saturates at
// the terminal count loaded with that clear.
// Ports: clk_i, reset_i (sync, active-high), clr_i (clear + load),
//        term_i (terminal count = phase length - 1), done_o (at terminal).
module dwell_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term_q, term_d;
  logic             done_q, done_d;

  // Next count: clear/load, count up, or hold once at terminal.
  always_comb begin
    cnt_d  = cnt_q;
    term_d = term_q;
    done_d = done_q;
    if (clr_i) begin
      cnt_d  = '0;
      term_d = term_i;
      done_d = (term_i == '0);
    end else if (!done_q) begin
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = ((cnt_q + CNT_W'(1)) == term_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      term_q <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/digit_scan_ctrl.sv
// Round-robin scan sequencer feeding a one-hot address decoder. Each
// enabled output gets a blanking gap then a dwell with addr_valid high.
// Ports: clk, reset (sync, active-high), enable (run level),
//        digit_mask (outputs taking part), address (selected index),
//        addr_valid (dwell phase), frame_done (wrap pulse), busy (not idle).
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned width        = 2,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2**width-1:0]   digit_mask,
  output logic [width-1:0]      address,
  output logic                  addr_valid,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned DWELL_TERM = DWELL_CYCLES - 1;
  localparam int unsigned BLANK_TERM = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  // With no blanking every digit goes straight into its dwell.
  localparam scan_state_t FIRST_PHASE = (BLANK_CYCLES == 0) ? DWELL : BLANK;

  scan_state_t        state_q, state_d;
  logic [width-1:0]   addr_q, addr_d;
  logic               valid_q;
  logic               frame_q, frame_d;
  logic               busy_q;

  logic               tmr_clr;
  logic [CNT_W-1:0]   tmr_term;
  logic               tmr_done;

  logic [MAX_N-1:0]      mask_ext;
  logic [MAX_ADDR_W-1:0] addr_ext;
  next_idx_t             nxt;

  assign mask_ext = MAX_N'(digit_mask);
  assign addr_ext = MAX_ADDR_W'(addr_q);

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (tmr_clr),
    .term_i  (tmr_term),
    .done_o  (tmr_done)
  );

  // Next state, next address and frame pulse; timer cleared on every entry.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    frame_d = 1'b0;
    tmr_clr = 1'b0;
    nxt     = next_enabled(mask_ext, addr_ext);
    unique case (state_q)
      IDLE: begin
        if (enable && (digit_mask != '0)) begin
          addr_d  = width'(lowest_set(mask_ext));
          state_d = FIRST_PHASE;
          tmr_clr = 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (tmr_done) begin
          state_d = DWELL;
          tmr_clr = 1'b1;
        end
      end
      DWELL: begin
        if (!enable) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (tmr_done) begin
          tmr_clr = 1'b1;
          if (nxt.found) begin
            addr_d  = width'(nxt.idx);
            state_d = FIRST_PHASE;
            // Wrap back to same or lower index closes a frame.
            frame_d = (width'(nxt.idx) <= addr_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    tmr_term = (state_d == BLANK) ? CNT_W'(BLANK_TERM) : CNT_W'(DWELL_TERM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= (state_d == DWELL);
      frame_q <= frame_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign address    = addr_q;
  assign addr_valid = valid_q;
  assign frame_done = frame_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed self-checking bench for digit_scan_ctrl (DWELL=4, BLANK=2).
module tb_digit_scan_ctrl;

  localparam int unsigned W      = 2;
  localparam int unsigned N      = 4;
  localparam int unsigned DWELL  = 4;
  localparam int unsigned BLNK   = 2;
  localparam int unsigned PERIOD = DWELL + BLNK;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] digit_mask;
  logic [W-1:0] address;
  logic         addr_valid;
  logic         frame_done;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  digit_scan_ctrl #(
    .width        (W),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLNK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digit_mask (digit_mask),
    .address    (address),
    .addr_valid (addr_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] a, input logic v,
                            input logic f, input logic b);
    check_eq({tag, " address"},    32'(address),    32'(a));
    check_eq({tag, " addr_valid"}, 32'(addr_valid), 32'(v));
    check_eq({tag, " frame_done"}, 32'(frame_done), 32'(f));
    check_eq({tag, " busy"},       32'(busy),       32'(b));
  endtask

  // Reset with the given mask applied, release, and take the IDLE exit edge.
  task automatic start_scan(input logic [N-1:0] m);
    reset      = 1'b1;
    enable     = 1'b1;
    digit_mask = m;
    step();
    check_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
  endtask

  // Steady scan: slot s holds seq[s % k]; blank then dwell; pulse on each slot-0 re-entry.
  task automatic check_scan(input string tag, input int k, input int s0, input int s1,
                            input int s2, input int s3, input int ncyc);
    int seq [4];
    int slot, phase;
    seq[0] = s0; seq[1] = s1; seq[2] = s2; seq[3] = s3;
    for (int c = 0; c < ncyc; c++) begin
      slot  = (c / int'(PERIOD)) % k;
      phase = c % int'(PERIOD);
      check_outs($sformatf("%s c%0d", tag, c), W'(seq[slot]), phase >= int'(BLNK),
                 (phase == 0) && (c >= int'(PERIOD)) && (slot == 0), 1'b1);
      step();
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    digit_mask = '0;
    step();
    check_outs("por", 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("idle_no_enable", 2'd0, 1'b0, 1'b0, 1'b0);

    // Enable with empty mask stays idle.
    reset  = 1'b0;
    enable = 1'b1;
    step();
    step();
    check_outs("idle_empty_mask", 2'd0, 1'b0, 1'b0, 1'b0);

    start_scan(4'b1111);
    check_scan("full", 4, 0, 1, 2, 3, 54);

    start_scan(4'b1010);
    check_scan("sparse", 2, 1, 3, 0, 0, 30);

    start_scan(4'b0100);
    check_scan("single", 1, 2, 0, 0, 0, 20);

    // Enable dropped in 2nd dwell cycle of address 2 (c=15).
    start_scan(4'b1111);
    for (int c = 0; c < 15; c++) step();
    check_outs("drop pre", 2'd2, 1'b1, 1'b0, 1'b1);
    enable = 1'b0;
    step();
    check_outs("drop idle", 2'd2, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("drop hold", 2'd2, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step();
    check_outs("reen blank0", 2'd0, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("reen blank1", 2'd0, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("reen dwell", 2'd0, 1'b1, 1'b0, 1'b1);

    // Mask cleared in 2nd dwell cycle of address 1 (c=9); dwell still completes.
    start_scan(4'b1111);
    for (int c = 0; c < 9; c++) step();
    digit_mask = 4'b0000;
    check_outs("mclr c9", 2'd1, 1'b1, 1'b0, 1'b1);
    step();
    check_outs("mclr c10", 2'd1, 1'b1, 1'b0, 1'b1);
    step();
    check_outs("mclr c11", 2'd1, 1'b1, 1'b0, 1'b1);
    step();
    check_outs("mclr idle", 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("mclr stay", 2'd1, 1'b0, 1'b0, 1'b0);

    // Reset pulse during blank of address 3 (c=18).
    start_scan(4'b1111);
    for (int c = 0; c < 18; c++) step();
    check_outs("rst pre", 2'd3, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    check_outs("rst hit", 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    check_outs("rst restart", 2'd0, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("rst blank1", 2'd0, 1'b0, 1'b0, 1'b1);
    step();
    check_outs("rst dwell", 2'd0, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
